booth4_pp_gen_seq: RTL

//  Sequential radix-4 modified-Booth encoder and partial-product generator: the producer feeding the 32-input Wallace reduction.

---
 rtl/booth4_pp_gen_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/booth4_pp_gen_seq.sv
// ---------------------------------------------------------------------------
// booth4_pp_gen_seq
//
// Sequential radix-4 modified-Booth encoder and partial-product generator.
// Accepts one signed operand pair (in_a = multiplicand, in_b = multiplier),
// recodes the multiplier into WIDTH/2 Booth digits and streams one PPW-bit
// two's-complement partial product per handshake. Modulo 2^PPW, the sum of
// all emitted partial products equals signed in_a * in_b.
//
// Optional build macro:
//   BOOTH_ZERO_SKIP_EN  - when defined, zero digits are not emitted. pp_idx
//                         still carries the true digit index, and pp_last
//                         marks the highest nonzero digit. An all-zero
//                         multiplier yields a single zero PP at index 0.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     block can accept operands (combinational from pp_ready)
//   in_a, in_b   signed multiplicand / multiplier, WIDTH bits
//   pp_valid     pp_data/pp_idx/pp_digit/pp_last valid
//   pp_ready     downstream accepts the current PP
//   pp_data      partial product, sign-extended, pre-shifted by 2*pp_idx
//   pp_idx       digit index of the current PP
//   pp_digit     Booth digit, 3-bit two's complement, -2..+2
//   pp_last      current PP is the final one of the operation
//   busy         operation in progress
// ---------------------------------------------------------------------------
module booth4_pp_gen_seq #(
  parameter int WIDTH = 64,
  parameter int PPW   = 2 * WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  output logic                           pp_valid,
  input  logic                           pp_ready,
  output logic [PPW-1:0]                 pp_data,
  output logic [$clog2(WIDTH/2)-1:0]     pp_idx,
  output logic [2:0]                     pp_digit,
  output logic                           pp_last,
  output logic                           busy
);

  localparam int NPP  = WIDTH / 2;
  localparam int IDXW = $clog2(NPP);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GEN  = 1'b1
  } state_t;

  // Booth recoding of one triplet {b[2i+1], b[2i], b[2i-1]} into a 3-bit
  // two's-complement digit.
  function automatic logic [2:0] recode(input logic [2:0] trip);
    logic [2:0] d;
    case (trip)
      3'b001, 3'b010: d = 3'b001;  // +1
      3'b011:         d = 3'b010;  // +2
      3'b100:         d = 3'b110;  // -2
      3'b101, 3'b110: d = 3'b111;  // -1
      default:        d = 3'b000;  // 000, 111
    endcase
    return d;
  endfunction

`ifdef BOOTH_ZERO_SKIP_EN
  // One bit per digit: set when that digit of b is nonzero.
  function automatic logic [NPP-1:0] nz_mask(input logic [WIDTH-1:0] b);
    logic [WIDTH:0]  be;
    logic [NPP-1:0]  m;
    be = {b, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      m[i] = (be[2*i +: 3] != 3'b000) && (be[2*i +: 3] != 3'b111);
    end
    return m;
  endfunction
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [IDXW-1:0]     r_idx;

  logic [WIDTH:0]      w_bext;
  logic [IDXW:0]       w_shamt;
  logic [2:0]          w_digit;
  logic [PPW-1:0]      w_a_ext;
  logic [PPW-1:0]      w_mag;
  logic [PPW-1:0]      w_pp;
  logic [IDXW-1:0]     w_next_idx;
  logic [IDXW-1:0]     w_first_idx;
  logic                w_last;
  logic                w_accept;
  logic                w_hs;

  // ---------------------------------------------------------------------
  // Datapath: recode the digit selected by r_idx and form its PP.
  // ---------------------------------------------------------------------
  assign w_bext  = {r_b, 1'b0};            // b[-1] = 0
  assign w_shamt = {r_idx, 1'b0};          // 2*idx
  assign w_digit = recode(w_bext[w_shamt +: 3]);
  assign w_a_ext = {{(PPW-WIDTH){r_a[WIDTH-1]}}, r_a};

  // Multiples are formed at PPW width, so -2A cannot overflow even for
  // the most negative multiplicand.
  always_comb begin
    case (w_digit)
      3'b001:  w_mag = w_a_ext;
      3'b010:  w_mag = w_a_ext << 1;
      3'b111:  w_mag = -w_a_ext;
      3'b110:  w_mag = -(w_a_ext << 1);
      default: w_mag = '0;
    endcase
  end

  assign w_pp = w_mag << w_shamt;

  // ---------------------------------------------------------------------
  // Digit sequencing. In zero-skip mode the next/first indices come from
  // a combinational priority search, so no bubble is inserted between PPs.
  // ---------------------------------------------------------------------
`ifdef BOOTH_ZERO_SKIP_EN
  logic [NPP-1:0] w_nz_cur;
  logic [NPP-1:0] w_nz_in;
  logic           w_has_next;

  assign w_nz_cur = nz_mask(r_b);
  assign w_nz_in  = nz_mask(in_b);

  always_comb begin
    w_next_idx  = '0;
    w_has_next  = 1'b0;
    w_first_idx = '0;
    // Scan downwards so the lowest qualifying index wins.
    for (int i = NPP - 1; i >= 0; i--) begin
      if (w_nz_cur[i] && (i > int'(r_idx))) begin
        w_next_idx = IDXW'(i);
        w_has_next = 1'b1;
      end
      if (w_nz_in[i]) begin
        w_first_idx = IDXW'(i);
      end
    end
  end

  // With no nonzero digit left above idx the current PP is the last one;
  // this also covers the all-zero multiplier (single PP at idx 0).
  assign w_last = !w_has_next;
`else
  assign w_next_idx  = r_idx + 1'b1;
  assign w_first_idx = '0;
  assign w_last      = (r_idx == IDXW'(NPP - 1));
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    pp_valid    = 1'b0;
    pp_last     = 1'b0;
    pp_data     = '0;
    pp_idx      = '0;
    pp_digit    = '0;
    busy        = 1'b0;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_hs        = 1'b0;

    if (r_state == S_GEN) begin
      pp_valid = 1'b1;
      busy     = 1'b1;
      pp_last  = w_last;
      pp_data  = w_pp;
      pp_idx   = r_idx;
      pp_digit = w_digit;
    end

    w_hs     = pp_valid && pp_ready;
    // Accepting during the final handshake chains operations with no bubble.
    in_ready = (r_state == S_IDLE) || (w_hs && pp_last);
    w_accept = in_valid && in_ready;

    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_GEN;
      S_GEN:   if (w_hs && w_last && !w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand capture and digit index
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_idx <= w_first_idx;
    end else if (w_hs && !w_last) begin
      r_idx <= w_next_idx;
    end
  end

endmodule
